// File: rtl/d_ext_pipe_pkg.sv
// Shared constants for the decode-stage immediate-extension pipe.
// Mode encodings, opcode width and the skid-buffer state type.
package d_ext_pipe_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] EXT_ZERO = 4'd0;
  localparam logic [OP_W-1:0] EXT_SIGN = 4'd1;
  localparam logic [OP_W-1:0] EXT_LUI  = 4'd2;
  localparam logic [OP_W-1:0] EXT_BOFS = 4'd3;
  localparam logic [OP_W-1:0] EXT_BTGT = 4'd5;
  localparam logic [OP_W-1:0] EXT_JTGT = 4'd6;

  // Encoding is {main valid, skid valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } buf_state_e;

endpackage

// File: rtl/d_ext_pipe_if.sv
// Request/response bundle of d_ext_pipe; master = producer/consumer side, slave = unit.
// D_EXT_PIPE_JADDR_EN adds the in_pc field used by the jump/branch-target modes.
interface d_ext_pipe_if
  import d_ext_pipe_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [IMM_W-1:0]  in_imm;
  logic [OP_W-1:0]   in_op;
  logic [TAG_W-1:0]  in_tag;
`ifdef D_EXT_PIPE_JADDR_EN
  logic [DATA_W-1:0] in_pc;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;

  modport master (
`ifdef D_EXT_PIPE_JADDR_EN
    output in_pc,
`endif
    output in_valid, in_imm, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
`ifdef D_EXT_PIPE_JADDR_EN
    input  in_pc,
`endif
    input  in_valid, in_imm, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );

endinterface

// File: rtl/d_ext_pipe_core.sv
// d_ext_core: combinational immediate-extension mode mux (imm, op, pc -> data, err).
// D_EXT_PIPE_JADDR_EN enables the pc-relative BTGT and JTGT modes.
module d_ext_core
  import d_ext_pipe_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic [IMM_W-1:0]  imm,
  input  logic [OP_W-1:0]   op,
`ifdef D_EXT_PIPE_JADDR_EN
  input  logic [DATA_W-1:0] pc,
`endif
  output logic [DATA_W-1:0] data,
  output logic              err
);

  logic [DATA_W-1:0] sext_s;
  logic [DATA_W-1:0] bofs_s;

  assign sext_s = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign bofs_s = {sext_s[DATA_W-3:0], 2'b00};

`ifdef D_EXT_PIPE_JADDR_EN
  // JTGT keeps the pc+4 bits above the shifted immediate field.
  localparam logic [DATA_W-1:0] JT_LOW_MASK = (DATA_W'(1'b1) << (IMM_W + 2)) - DATA_W'(1'b1);

  logic [DATA_W-1:0] pc_plus4_s;
  logic [DATA_W-1:0] btgt_s;
  logic [DATA_W-1:0] jtgt_s;

  assign pc_plus4_s = pc + DATA_W'(3'd4);
  assign btgt_s     = pc_plus4_s + bofs_s;
  assign jtgt_s     = (pc_plus4_s & ~JT_LOW_MASK) | DATA_W'({imm, 2'b00});
`endif

  // Mode select; undefined modes return zero with the error flag set.
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (op)
      EXT_ZERO: data = DATA_W'(imm);
      EXT_SIGN: data = sext_s;
      EXT_LUI:  data = {imm, {(DATA_W-IMM_W){1'b0}}};
      EXT_BOFS: data = bofs_s;
`ifdef D_EXT_PIPE_JADDR_EN
      EXT_BTGT: data = btgt_s;
      EXT_JTGT: data = jtgt_s;
`endif
      default: begin
        data = '0;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/d_ext_pipe.sv
// d_ext_pipe: registered immediate-extension stage with a 2-entry skid buffer.
// D_EXT_PIPE_JADDR_EN adds the pc input and the BTGT/JTGT modes.
module d_ext_pipe
  import d_ext_pipe_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  d_ext_pipe_if.slave  bus
);

  logic [DATA_W-1:0] ext_data_s;
  logic              ext_err_s;

  buf_state_e        state_r;
  buf_state_e        state_s;
  logic              in_ready_r;
  logic              in_fire_s;
  logic              out_fire_s;
  logic              load_m_in_s;
  logic              load_m_skid_s;
  logic              load_s_s;

  logic [DATA_W-1:0] m_data_r;
  logic [TAG_W-1:0]  m_tag_r;
  logic              m_err_r;
  logic [DATA_W-1:0] s_data_r;
  logic [TAG_W-1:0]  s_tag_r;
  logic              s_err_r;

  d_ext_core #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_core (
    .imm  (bus.in_imm),
    .op   (bus.in_op),
`ifdef D_EXT_PIPE_JADDR_EN
    .pc   (bus.in_pc),
`endif
    .data (ext_data_s),
    .err  (ext_err_s)
  );

  // An input offered during flush is dropped even when in_ready is high.
  assign in_fire_s  = bus.in_valid && in_ready_r && !flush;
  assign out_fire_s = (state_r != ST_EMPTY) && bus.out_ready;

  // Buffer occupancy state register; in_ready is registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_EMPTY;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s != ST_FULL);
    end
  end

  // Next-state and load-enable decode for the main/skid entries.
  always_comb begin
    state_s       = state_r;
    load_m_in_s   = 1'b0;
    load_m_skid_s = 1'b0;
    load_s_s      = 1'b0;
    if (flush) begin
      state_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_s     = ST_ONE;
            load_m_in_s = 1'b1;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            load_m_in_s = 1'b1;
          end else if (in_fire_s) begin
            state_s  = ST_FULL;
            load_s_s = 1'b1;
          end else if (out_fire_s) begin
            state_s = ST_EMPTY;
          end else begin
            state_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            state_s       = ST_ONE;
            load_m_skid_s = 1'b1;
          end else begin
            state_s = ST_FULL;
          end
        end
        default: state_s = ST_EMPTY;
      endcase
    end
  end

  // Entry payloads; only reset clears them so flushed data stays visible but invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_data_r <= '0;
      m_tag_r  <= '0;
      m_err_r  <= 1'b0;
      s_data_r <= '0;
      s_tag_r  <= '0;
      s_err_r  <= 1'b0;
    end else begin
      if (load_m_in_s) begin
        m_data_r <= ext_data_s;
        m_tag_r  <= bus.in_tag;
        m_err_r  <= ext_err_s;
      end else if (load_m_skid_s) begin
        m_data_r <= s_data_r;
        m_tag_r  <= s_tag_r;
        m_err_r  <= s_err_r;
      end
      if (load_s_s) begin
        s_data_r <= ext_data_s;
        s_tag_r  <= bus.in_tag;
        s_err_r  <= ext_err_s;
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = (state_r != ST_EMPTY);
  assign bus.out_data  = m_data_r;
  assign bus.out_tag   = m_tag_r;
  assign bus.out_err   = m_err_r;

endmodule

// File: tb/tb_d_ext_pipe.sv
// Scoreboard bench for d_ext_pipe: directed scenarios plus randomized traffic.
// Define D_EXT_PIPE_JADDR_EN for both bench and RTL to cover BTGT/JTGT.
module tb_d_ext_pipe;
  import d_ext_pipe_pkg::*;

  localparam int IMM_W  = 16;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  logic [DATA_W-1:0] mon_pc;

  d_ext_pipe_if #(.IMM_W(IMM_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) b ();

  d_ext_pipe #(.IMM_W(IMM_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (b.slave)
  );

`ifdef D_EXT_PIPE_JADDR_EN
  assign mon_pc = b.in_pc;
`else
  assign mon_pc = 32'h0;
`endif

  always #5 clk = ~clk;

  // Reference: extension rules evaluated on signed integers, reduced mod 2^32.
  function automatic logic [32:0] model(input logic [15:0] imm, input logic [3:0] op,
                                        input logic [31:0] pc);
    longint sv;
    longint r;
    logic   err;
    sv = longint'(imm);
    if (imm[15]) sv = sv - 65536;
    err = 1'b0;
    r   = 0;
    case (op)
      4'd0: r = longint'(imm);
      4'd1: r = sv;
      4'd2: r = longint'(imm) * 65536;
      4'd3: r = sv * 4;
`ifdef D_EXT_PIPE_JADDR_EN
      4'd5: r = longint'(pc) + 4 + sv * 4;
      4'd6: r = ((longint'(pc) + 4) / 262144) * 262144 + longint'(imm) * 4;
`endif
      default: begin
        r   = 0;
        err = 1'b1;
      end
    endcase
    if (pc == 32'hFFFF_FFFF && op == 4'd15) err = err;
    return {err, r[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic [3:0] op,
                       input logic [4:0] tag);
    b.in_valid = v;
    b.in_imm   = imm;
    b.in_op    = op;
    b.in_tag   = tag;
  endtask

  // Monitor: pops/compares on output transfers, pushes on input transfers, checks hold.
  initial begin
    exp_t        e;
    logic [32:0] m;
    logic        stall_pend = 1'b0;
    logic [37:0] held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        stall_pend = 1'b0;
      end else begin
        if (stall_pend) begin
          check("hold_valid", 64'(b.out_valid), 64'd1);
          check("hold_payload", 64'({b.out_data, b.out_tag, b.out_err}), 64'(held));
        end
        if (b.out_valid && b.out_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got tag %0d data %0h, expected none",
                     b.out_tag, b.out_data);
          end else begin
            e = exp_q.pop_front();
            check("sb_data", 64'(b.out_data), 64'(e.data));
            check("sb_tag",  64'(b.out_tag),  64'(e.tag));
            check("sb_err",  64'(b.out_err),  64'(e.err));
          end
        end
        stall_pend = b.out_valid && !b.out_ready && !flush;
        held       = {b.out_data, b.out_tag, b.out_err};
        if (flush) begin
          exp_q.delete();
        end else if (b.in_valid && b.in_ready) begin
          m = model(b.in_imm, b.in_op, mon_pc);
          e.data = m[31:0];
          e.err  = m[32];
          e.tag  = b.in_tag;
          exp_q.push_back(e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    b.out_ready = 1'b0;
    drive(1'b0, 16'h0, 4'd0, 5'd0);
`ifdef D_EXT_PIPE_JADDR_EN
    b.in_pc = 32'h0;
`endif
    step();
    step();
    check("rst_out_valid", 64'(b.out_valid), 64'd0);
    check("rst_out_data",  64'(b.out_data),  64'd0);
    check("rst_out_tag",   64'(b.out_tag),   64'd0);
    check("rst_out_err",   64'(b.out_err),   64'd0);
    check("rst_in_ready",  64'(b.in_ready),  64'd1);
    reset = 1'b0;

    // Modes on consecutive cycles, 1-cycle latency.
    b.out_ready = 1'b1;
    drive(1'b1, 16'h8001, 4'd0, 5'd1); step();
    check("zero_data", 64'(b.out_data), 64'h0000_8001);
    check("zero_valid", 64'(b.out_valid), 64'd1);
    drive(1'b1, 16'h8001, 4'd1, 5'd2); step();
    check("sign_data", 64'(b.out_data), 64'hFFFF_8001);
    drive(1'b1, 16'h8001, 4'd2, 5'd3); step();
    check("lui_data", 64'(b.out_data), 64'h8001_0000);
    drive(1'b1, 16'h8001, 4'd3, 5'd4); step();
    check("bofs_data", 64'(b.out_data), 64'hFFFE_0004);
    check("bofs_err", 64'(b.out_err), 64'd0);

    // Undefined mode.
    drive(1'b1, 16'h1234, 4'd9, 5'd17); step();
    check("undef_data", 64'(b.out_data), 64'd0);
    check("undef_err",  64'(b.out_err),  64'd1);
    check("undef_tag",  64'(b.out_tag),  64'd17);
    drive(1'b0, 16'h0, 4'd0, 5'd0); step();

    // Backpressure: third request held until the buffer drains.
    b.out_ready = 1'b0;
    drive(1'b1, 16'd1, 4'd0, 5'd1); step();
    check("bp_ready_one", 64'(b.in_ready), 64'd1);
    drive(1'b1, 16'd2, 4'd0, 5'd2); step();
    check("bp_ready_full", 64'(b.in_ready), 64'd0);
    drive(1'b1, 16'd3, 4'd0, 5'd3); step();
    check("bp_ready_held", 64'(b.in_ready), 64'd0);
    check("bp_head_tag", 64'(b.out_tag), 64'd1);
    step();
    b.out_ready = 1'b1; step();
    check("bp_tag2", 64'(b.out_tag), 64'd2);
    check("bp_ready_back", 64'(b.in_ready), 64'd1);
    step();
    check("bp_tag3", 64'(b.out_tag), 64'd3);
    drive(1'b0, 16'h0, 4'd0, 5'd0); step();
    check("bp_drained", 64'(b.out_valid), 64'd0);

    // Flush while FULL with a request offered.
    b.out_ready = 1'b0;
    drive(1'b1, 16'd4, 4'd0, 5'd4); step();
    drive(1'b1, 16'd5, 4'd0, 5'd5); step();
    drive(1'b1, 16'd7, 4'd0, 5'd7);
    flush = 1'b1; step();
    flush = 1'b0;
    drive(1'b0, 16'h0, 4'd0, 5'd0);
    check("flush_full_valid", 64'(b.out_valid), 64'd0);
    check("flush_full_ready", 64'(b.in_ready), 64'd1);
    b.out_ready = 1'b1; step(); step();
    check("flush_full_quiet", 64'(b.out_valid), 64'd0);

    // Flush while ONE: the offered request is dropped although in_ready=1.
    b.out_ready = 1'b0;
    drive(1'b1, 16'd8, 4'd0, 5'd8); step();
    drive(1'b1, 16'd9, 4'd0, 5'd9);
    flush = 1'b1; step();
    flush = 1'b0;
    drive(1'b0, 16'h0, 4'd0, 5'd0);
    check("flush_one_valid", 64'(b.out_valid), 64'd0);
    b.out_ready = 1'b1; step();
    check("flush_one_quiet", 64'(b.out_valid), 64'd0);

    // Reset while FULL.
    b.out_ready = 1'b0;
    drive(1'b1, 16'hA5A5, 4'd1, 5'd10); step();
    drive(1'b1, 16'h5A5A, 4'd2, 5'd11); step();
    drive(1'b0, 16'h0, 4'd0, 5'd0);
    reset = 1'b1; step();
    reset = 1'b0;
    check("rstf_out_valid", 64'(b.out_valid), 64'd0);
    check("rstf_out_data",  64'(b.out_data),  64'd0);
    check("rstf_out_tag",   64'(b.out_tag),   64'd0);
    check("rstf_out_err",   64'(b.out_err),   64'd0);
    check("rstf_in_ready",  64'(b.in_ready),  64'd1);

`ifdef D_EXT_PIPE_JADDR_EN
    b.out_ready = 1'b1;
    b.in_pc = 32'h0000_3000;
    drive(1'b1, 16'hFFFF, 4'd5, 5'd12); step();
    check("btgt_data", 64'(b.out_data), 64'h0000_3000);
    check("btgt_err",  64'(b.out_err),  64'd0);
    b.in_pc = 32'h4000_0000;
    drive(1'b1, 16'h1234, 4'd6, 5'd13); step();
    check("jtgt_data", 64'(b.out_data), 64'h4000_48D0);
    check("jtgt_err",  64'(b.out_err),  64'd0);
    drive(1'b0, 16'h0, 4'd0, 5'd0); step();
`endif

    // Randomized traffic with backpressure and occasional flush.
    for (int i = 0; i < 3000; i++) begin
      b.in_valid  = ($urandom_range(9) < 7);
      b.in_imm    = 16'($urandom);
      b.in_op     = ($urandom_range(3) == 0) ? 4'($urandom) : 4'($urandom_range(6));
      b.in_tag    = 5'($urandom);
`ifdef D_EXT_PIPE_JADDR_EN
      b.in_pc     = 32'($urandom);
`endif
      b.out_ready = ($urandom_range(9) < 6);
      flush       = ($urandom_range(49) == 0);
      step();
    end

    flush = 1'b0;
    drive(1'b0, 16'h0, 4'd0, 5'd0);
    b.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    check("drain_out_valid", 64'(b.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
